// File: rtl/pulse_seq_pkg.sv
// -----------------------------------------------------------------------------
// pulse_seq_pkg
// Shared definitions for the four-phase single-wire handshake generator.
//   state_e      : generator FSM state encoding (3 bits)
//   PH_*         : Phase codes, identical to the receiver's Idle/Start/Stop/Clear
//   phase_of()   : expected receiver phase for a generator state
//   level_of()   : serial-line level driven in a generator state
// -----------------------------------------------------------------------------
package pulse_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HI1  = 3'd1,
    ST_LO1  = 3'd2,
    ST_HI2  = 3'd3,
    ST_LO2  = 3'd4
  } state_e;

  localparam logic [1:0] PH_IDLE  = 2'b00;
  localparam logic [1:0] PH_START = 2'b01;
  localparam logic [1:0] PH_STOP  = 2'b10;
  localparam logic [1:0] PH_CLEAR = 2'b11;

  // LO2 reports Idle: the receiver is already heading back to Idle there.
  function automatic logic [1:0] phase_of(input state_e s);
    case (s)
      ST_HI1:  return PH_START;
      ST_LO1:  return PH_STOP;
      ST_HI2:  return PH_CLEAR;
      ST_LO2:  return PH_IDLE;
      default: return PH_IDLE;
    endcase
  endfunction

  function automatic logic level_of(input state_e s);
    return (s == ST_HI1) || (s == ST_HI2);
  endfunction

endpackage

// File: rtl/pulse_seq_gen_phase_timer.sv
// -----------------------------------------------------------------------------
// phase_timer
// Loadable down-counter that saturates at zero.
//   clk_i       : rising-edge clock
//   rst_i       : synchronous active-high reset (count -> 0)
//   load_i      : load load_val_i (takes priority over dec_i)
//   load_val_i  : value to load
//   dec_i       : decrement request, ignored when the count is already zero
//   zero_o      : count equals zero
// -----------------------------------------------------------------------------
module phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  assign zero_o = (count_q == '0);

  // Next count: load, guarded decrement, or hold.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && !zero_o) begin
      count_d = count_q - ONE;
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/pulse_seq_gen.sv
// -----------------------------------------------------------------------------
// pulse_seq_gen
// Drives serial line A through high/low/high/low phases of programmable
// length, repeated Reps times, and reports the receiver phase to expect.
//   Clock  : rising-edge clock
//   Reset  : synchronous active-high reset
//   Go     : start request, honoured only while idle and not aborting
//   Abort  : ends any running sequence without Done
//   HiLen  : cycles per high phase (0 means 1), latched on accepted Go
//   LoLen  : cycles per low phase  (0 means 1), latched on accepted Go
//   Reps   : repetitions           (0 means 1), latched on accepted Go
//   A      : serial line (registered)
//   Busy   : sequence running (registered)
//   Done   : one-cycle completion pulse (registered)
//   Phase  : expected receiver state (registered)
// -----------------------------------------------------------------------------
module pulse_seq_gen
  import pulse_seq_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Go,
  input  logic             Abort,
  input  logic [CNT_W-1:0] HiLen,
  input  logic [CNT_W-1:0] LoLen,
  input  logic [CNT_W-1:0] Reps,
  output logic             A,
  output logic             Busy,
  output logic             Done,
  output logic [1:0]       Phase
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] hi_m1_q;
  logic [CNT_W-1:0] lo_m1_q;
  logic             a_q;
  logic             busy_q;
  logic             done_q;
  logic             done_d;
  logic [1:0]       phase_q;

  logic             start_s;
  logic [CNT_W-1:0] hi_in_m1_s;
  logic [CNT_W-1:0] lo_in_m1_s;
  logic [CNT_W-1:0] reps_in_m1_s;

  logic             ph_load_s;
  logic [CNT_W-1:0] ph_val_s;
  logic             ph_dec_s;
  logic             ph_zero_s;
  logic             rep_load_s;
  logic             rep_dec_s;
  logic             rep_zero_s;

  // A programmed zero behaves as one, so "length minus one" of zero is zero.
  assign hi_in_m1_s   = (HiLen == '0) ? '0 : HiLen - ONE;
  assign lo_in_m1_s   = (LoLen == '0) ? '0 : LoLen - ONE;
  assign reps_in_m1_s = (Reps  == '0) ? '0 : Reps  - ONE;

  assign start_s = (state_q == ST_IDLE) && Go && !Abort;

  phase_timer #(.CNT_W(CNT_W)) u_phase_cnt (
    .clk_i      (Clock),
    .rst_i      (Reset),
    .load_i     (ph_load_s),
    .load_val_i (ph_val_s),
    .dec_i      (ph_dec_s),
    .zero_o     (ph_zero_s)
  );

  phase_timer #(.CNT_W(CNT_W)) u_rep_cnt (
    .clk_i      (Clock),
    .rst_i      (Reset),
    .load_i     (rep_load_s),
    .load_val_i (reps_in_m1_s),
    .dec_i      (rep_dec_s),
    .zero_o     (rep_zero_s)
  );

  // Next state and counter controls; the zero check precedes any decrement.
  always_comb begin
    state_d    = state_q;
    done_d     = 1'b0;
    ph_load_s  = 1'b0;
    ph_val_s   = hi_m1_q;
    ph_dec_s   = 1'b0;
    rep_load_s = 1'b0;
    rep_dec_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_s) begin
          state_d    = ST_HI1;
          ph_load_s  = 1'b1;
          ph_val_s   = hi_in_m1_s;
          rep_load_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HI1, ST_LO1, ST_HI2, ST_LO2: begin
        if (Abort) begin
          state_d = ST_IDLE;
        end else if (!ph_zero_s) begin
          ph_dec_s = 1'b1;
        end else begin
          case (state_q)
            ST_HI1: begin
              state_d   = ST_LO1;
              ph_load_s = 1'b1;
              ph_val_s  = lo_m1_q;
            end
            ST_LO1: begin
              state_d   = ST_HI2;
              ph_load_s = 1'b1;
              ph_val_s  = hi_m1_q;
            end
            ST_HI2: begin
              state_d   = ST_LO2;
              ph_load_s = 1'b1;
              ph_val_s  = lo_m1_q;
            end
            ST_LO2: begin
              if (!rep_zero_s) begin
                state_d   = ST_HI1;
                ph_load_s = 1'b1;
                ph_val_s  = hi_m1_q;
                rep_dec_s = 1'b1;
              end else begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
              end
            end
            default: state_d = ST_IDLE;
          endcase
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state, shadow lengths and outputs, all registered from the next state.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      hi_m1_q <= '0;
      lo_m1_q <= '0;
      a_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      phase_q <= PH_IDLE;
    end else begin
      state_q <= state_d;
      if (start_s) begin
        hi_m1_q <= hi_in_m1_s;
        lo_m1_q <= lo_in_m1_s;
      end
      a_q     <= level_of(state_d);
      busy_q  <= (state_d != ST_IDLE);
      done_q  <= done_d;
      phase_q <= phase_of(state_d);
    end
  end

  assign A     = a_q;
  assign Busy  = busy_q;
  assign Done  = done_q;
  assign Phase = phase_q;

endmodule

// File: tb/tb_pulse_seq_gen.sv
// Self-checking bench for pulse_seq_gen: per-scenario tasks, randomized
// lengths and mid-run noise, a list-based expected waveform and a small
// receiver model on the serial line.
module tb_pulse_seq_gen;

  logic       Clock;
  logic       Reset;
  logic       Go;
  logic       Abort;
  logic [7:0] HiLen;
  logic [7:0] LoLen;
  logic [7:0] Reps;
  logic       A;
  logic       Busy;
  logic       Done;
  logic [1:0] Phase;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic       exp_a[$];
  logic [1:0] exp_ph[$];

  // Receiver model: Idle=0, Start=1, Stop=2, Clear=3; G counted on Clear->Idle.
  logic [1:0] rx_q;
  int         g_cnt;

  pulse_seq_gen #(.CNT_W(8)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .Go    (Go),
    .Abort (Abort),
    .HiLen (HiLen),
    .LoLen (LoLen),
    .Reps  (Reps),
    .A     (A),
    .Busy  (Busy),
    .Done  (Done),
    .Phase (Phase)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  always @(posedge Clock) begin
    if (Reset) begin
      rx_q  <= 2'd0;
      g_cnt <= 0;
    end else begin
      case (rx_q)
        2'd0: if (A)  rx_q <= 2'd1;
        2'd1: if (!A) rx_q <= 2'd2;
        2'd2: if (A)  rx_q <= 2'd3;
        default: if (!A) begin rx_q <= 2'd0; g_cnt <= g_cnt + 1; end
      endcase
    end
  end

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  // Expected per-cycle A/Phase list straight from the phase rules.
  task automatic build_model(input int h, input int l, input int r);
    int he, le, re;
    he = (h == 0) ? 1 : h;
    le = (l == 0) ? 1 : l;
    re = (r == 0) ? 1 : r;
    exp_a.delete();
    exp_ph.delete();
    for (int k = 0; k < re; k++) begin
      for (int i = 0; i < he; i++) begin exp_a.push_back(1'b1); exp_ph.push_back(2'b01); end
      for (int i = 0; i < le; i++) begin exp_a.push_back(1'b0); exp_ph.push_back(2'b10); end
      for (int i = 0; i < he; i++) begin exp_a.push_back(1'b1); exp_ph.push_back(2'b11); end
      for (int i = 0; i < le; i++) begin exp_a.push_back(1'b0); exp_ph.push_back(2'b00); end
    end
  endtask

  // Launches one sequence and checks every cycle up to and including Done.
  task automatic run_sequence(input string name, input int h, input int l,
                              input int r, input bit noise);
    logic [4:0] exp_v;
    build_model(h, l, r);
    HiLen = 8'(h);
    LoLen = 8'(l);
    Reps  = 8'(r);
    Go    = 1'b1;
    for (int i = 0; i < exp_a.size(); i++) begin
      step();
      Go = 1'b0;
      if (noise) begin
        Go    = 1'($urandom_range(0, 1));
        HiLen = 8'($urandom);
        LoLen = 8'($urandom);
        Reps  = 8'($urandom);
      end
      exp_v = {exp_a[i], 1'b1, 1'b0, exp_ph[i]};
      total_cnt++;
      if ({A, Busy, Done, Phase} !== exp_v) begin
        $display("FAIL %s cycle %0d: {A,Busy,Done,Phase}=%b expected %b",
                 name, i, {A, Busy, Done, Phase}, exp_v);
      end else begin
        pass_cnt++;
      end
    end
    Go = 1'b0;
    step();
    total_cnt++;
    if ({A, Busy, Done, Phase} !== 5'b00100) begin
      $display("FAIL %s done: {A,Busy,Done,Phase}=%b expected 00100",
               name, {A, Busy, Done, Phase});
    end else begin
      pass_cnt++;
    end
  endtask

  task automatic expect_idle(input string name);
    total_cnt++;
    if ({A, Busy, Done, Phase} !== 5'b00000) begin
      $display("FAIL %s: {A,Busy,Done,Phase}=%b expected 00000",
               name, {A, Busy, Done, Phase});
    end else begin
      pass_cnt++;
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1; Go = 1'b1; Abort = 1'b0;
    HiLen = 8'd3; LoLen = 8'd2; Reps = 8'd1;
    for (int i = 0; i < 3; i++) begin
      step();
      expect_idle("reset_hold");
    end
    Reset = 1'b0; Go = 1'b0;
    step();
    expect_idle("reset_release_no_go");
    // Reset released with Go still high starts a sequence.
    Reset = 1'b1; Go = 1'b1;
    step();
    Reset = 1'b0;
    step();
    Go = 1'b0;
    total_cnt++;
    if ({A, Busy, Phase} !== 4'b1101) begin
      $display("FAIL reset_release_go: {A,Busy,Phase}=%b expected 1101", {A, Busy, Phase});
    end else begin
      pass_cnt++;
    end
    step();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    expect_idle("reset_mid_sequence");
    step();
    expect_idle("reset_mid_after");
  endtask

  task automatic test_basic();
    run_sequence("basic_3_2_1", 3, 2, 1, 1'b0);
    step();
    expect_idle("basic_done_drop");
  endtask

  task automatic test_zero_lengths();
    run_sequence("zero_lengths", 0, 0, 0, 1'b0);
    step();
    expect_idle("zero_done_drop");
  endtask

  task automatic test_reps_go_ignored();
    run_sequence("reps_1_1_3_noise", 1, 1, 3, 1'b1);
    Go = 1'b0;
    step();
    expect_idle("reps_single_done");
  endtask

  task automatic test_abort();
    HiLen = 8'd3; LoLen = 8'd2; Reps = 8'd1;
    Go = 1'b1;
    step();
    Go = 1'b0;
    for (int i = 0; i < 3; i++) step();
    total_cnt++;
    if ({A, Phase} !== 3'b010) begin
      $display("FAIL abort_in_lo1: {A,Phase}=%b expected 010", {A, Phase});
    end else begin
      pass_cnt++;
    end
    Abort = 1'b1;
    step();
    Abort = 1'b0;
    expect_idle("abort_next_edge");
    for (int i = 0; i < 8; i++) begin
      step();
      expect_idle("abort_no_done");
    end
    Go = 1'b1; Abort = 1'b1;
    step();
    Go = 1'b0; Abort = 1'b0;
    expect_idle("go_abort_same_cycle");
    step();
    expect_idle("go_abort_after");
  endtask

  task automatic test_back_to_back();
    run_sequence("b2b_first", 2, 1, 1, 1'b0);
    run_sequence("b2b_second", 1, 2, 2, 1'b0);
    step();
    expect_idle("b2b_done_drop");
  endtask

  task automatic test_random();
    for (int n = 0; n < 8; n++) begin
      run_sequence("random", int'($urandom_range(0, 5)), int'($urandom_range(0, 5)),
                   int'($urandom_range(0, 3)), 1'b1);
      Go = 1'b0;
      step();
      expect_idle("random_done_drop");
    end
  endtask

  task automatic test_receiver();
    logic [1:0] prev_ph;
    bit         f_seen;
    f_seen = 1'b0;
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    HiLen = 8'd2; LoLen = 8'd4; Reps = 8'd2;
    Go = 1'b1;
    prev_ph = Phase;
    for (int i = 0; i < 26; i++) begin
      step();
      Go = 1'b0;
      total_cnt++;
      if (rx_q !== prev_ph) begin
        $display("FAIL receiver_phase cycle %0d: rx=%b expected %b", i, rx_q, prev_ph);
      end else begin
        pass_cnt++;
      end
      if (rx_q == 2'd3) f_seen = 1'b1;
      prev_ph = Phase;
    end
    total_cnt++;
    if (g_cnt !== 2 || !f_seen) begin
      $display("FAIL receiver_g: g_cnt=%0d f_seen=%0b expected 2 and 1", g_cnt, f_seen);
    end else begin
      pass_cnt++;
    end
  endtask

  initial begin
    Reset = 1'b1; Go = 1'b0; Abort = 1'b0;
    HiLen = 8'd0; LoLen = 8'd0; Reps = 8'd0;
    test_reset();
    test_basic();
    test_zero_lengths();
    test_reps_go_ignored();
    test_abort();
    test_back_to_back();
    test_random();
    test_receiver();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/pulse_seq_gen.md
# pulse_seq_gen

Stimulus-side generator for the four-phase single-wire handshake decoded by the team's Idle/Start/Stop/Clear receiver FSM. On command it drives the serial line `A` through high, low, high, low phases of programmable length, repeated a programmable number of times. It reports the phase the receiver should be in and pulses `Done` on completion. It sits upstream of the receiver, in the same clock domain, and is used both in-system and as the bench driver for the receiver.

## Interface
- `CNT_W`, default 8: width of the phase-length and repeat-count inputs.
- `Clock`  in  1  rising-edge clock.
- `Reset`  in  1  synchronous, active-high reset.
- `Go`  in  1  start request; sampled only while idle.
- `Abort`  in  1  synchronous abort; ends any sequence in progress.
- `HiLen`  in  CNT_W  cycles per high phase; latched on accepted `Go`.
- `LoLen`  in  CNT_W  cycles per low phase; latched on accepted `Go`.
- `Reps`  in  CNT_W  number of full high-low-high-low repetitions; latched on accepted `Go`.
- `A`  out  1  serial line to the receiver, registered.
- `Busy`  out  1  high while a sequence is running.
- `Done`  out  1  one-cycle pulse when the last repetition completes.
- `Phase`  out  2  expected receiver state: 00 Idle, 01 Start, 10 Stop, 11 Clear.

## Operation
- States:
  - IDLE
  - HI1 (A=1, Phase=01)
  - LO1 (A=0, Phase=10)
  - HI2 (A=1, Phase=11)
  - LO2 (A=0, Phase=00)
- IDLE drives A=0, Phase=00, Busy=0.
- Accepted `Go` (IDLE, Abort=0):
  - latch lengths into shadow registers;
  - zero values are treated as 1;
  - phase counter <= HiLen'-1, repeat counter <= Reps'-1;
  - next state HI1.
- In any active state, each edge does one of the following:
  - counter != 0: decrement.
  - counter == 0: advance HI1->LO1->HI2->LO2, loading LoLen'-1 or HiLen'-1 as appropriate.
- At LO2 with counter == 0:
  - repeat counter != 0: decrement it, go to HI1, load HiLen'-1.
  - repeat counter == 0: go to IDLE and pulse `Done`.
- Each phase therefore holds its level for exactly its programmed length.
- `Go` while Busy is ignored. Shadow values are unaffected by input changes mid-sequence.
- `Abort` in any active state: next edge forces IDLE, A=0, Busy=0, no `Done`. `Abort` in IDLE has no effect.
- `Abort` and `Go` in the same cycle: `Abort` wins and the sequence does not start.
- Arithmetic: counters are CNT_W bits, decrement only, and never underflow; the zero check precedes the decrement.

## Timing
- Reset values: A=0, Busy=0, Done=0, Phase=00, state IDLE, all counters 0.
- `Reset` overrides `Go` and `Abort`. `Reset` mid-sequence returns to reset values on the next edge with no `Done`.
- Latency: `Go` sampled at edge t0. A, Busy and Phase change at t0, so A is high in the cycle following t0.
- Sequence length: 2*(H+L)*R cycles from edge t0, where H, L, R are the post-zero-substitution values.
- At the final edge: Done=1, Busy=0, A=0, all together. Done drops on the next edge.
- Back-to-back: a new `Go` can be accepted in the same cycle that Done=1, because the state is IDLE. No dead cycle between sequences.
- Phase mirrors the receiver's state one cycle after the A transition it reacts to. Scoreboards compare `Phase` against the receiver state with a one-cycle delay.

## Structure
- Package `pulse_seq_pkg`:
  - state encoding constants (3-bit: IDLE, HI1, LO1, HI2, LO2);
  - Phase codes 00/01/10/11, shared with the receiver's Idle/Start/Stop/Clear encoding.
- Sub-module `phase_timer`: loadable CNT_W down-counter with a `zero` flag, instantiated twice (phase count and repeat count).
- Top level holds the FSM, shadow registers and output registers.

## Test plan
- Reset held high for 3 cycles while Go=1 -> A=0, Busy=0, Done=0, Phase=00 throughout. No start after Reset drops unless Go is still high.
- HiLen=3, LoLen=2, Reps=1, Go for one cycle -> A=1,1,1,0,0,1,1,1,0,0. Phase=01,01,01,10,10,11,11,11,00,00. Done=1 in cycle 11, Busy low from then.
- HiLen=0, LoLen=0, Reps=0 -> treated as 1/1/1. A=1,0,1,0, then Done.
- HiLen=1, LoLen=1, Reps=3 -> A toggles 12 times. A single Done after cycle 12. Go pulses mid-run ignored.
- Abort asserted in the fourth cycle of the HiLen=3/LoLen=2 run (LO1) -> A=0, Busy=0, Phase=00 at the next edge. Done never asserts. Go+Abort in the same cycle -> no start.
- Receiver FSM connected to A, HiLen=2, LoLen=4, Reps=2 -> the receiver's F rises in Clear and G pulses at each return to Idle, twice. Receiver state equals Phase delayed one cycle on every cycle.
